// File: rtl/tx_uart_fifo_if.sv
// Host-side port bundle for tx_uart_fifo: baud control, byte push, FIFO flags and the serial pin.
// The parity_odd member exists only when TX_UART_PARITY_EN is defined.
interface tx_uart_fifo_if;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_busy;
    logic        tx_pin;
    logic [2:0]  state_dbg;
`ifdef TX_UART_PARITY_EN
    logic        parity_odd;
`endif

    // Push handshake: tx_data is taken on every clk edge where tx_wr=1 and either tx_full=0
    // or the transmitter pops in that same cycle; otherwise the byte is silently dropped.
`ifdef TX_UART_PARITY_EN
    modport master (
        output baud_div, tx_data, tx_wr, parity_odd,
        input  tx_full, tx_empty, tx_busy, tx_pin, state_dbg
    );
    modport slave (
        input  baud_div, tx_data, tx_wr, parity_odd,
        output tx_full, tx_empty, tx_busy, tx_pin, state_dbg
    );
`else
    modport master (
        output baud_div, tx_data, tx_wr,
        input  tx_full, tx_empty, tx_busy, tx_pin, state_dbg
    );
    modport slave (
        input  baud_div, tx_data, tx_wr,
        output tx_full, tx_empty, tx_busy, tx_pin, state_dbg
    );
`endif
endinterface

// File: rtl/tx_uart_fifo.sv
// UART transmitter (8N1, LSB first, bit = baud_div+1 clocks) fed by a circular byte FIFO.
// Optional feature macro: TX_UART_PARITY_EN adds a parity bit (parity_odd selects odd).
module tx_uart_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_uart_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        pin_q, pin_d;
`ifdef TX_UART_PARITY_EN
    logic        par_q, par_d;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push, pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign pop  = (state_q == IDLE) && !empty_q;
    assign push = bus.tx_wr && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
`ifdef TX_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
`ifdef TX_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The timer reloads from baud_div at every bit start, so a new rate applies from the next bit.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pin_d   = pin_q;
`ifdef TX_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                pin_d = 1'b1;
                if (pop) begin
                    shift_d = mem[rd_ptr];
                    pin_d   = 1'b0;
                    timer_d = bus.baud_div;
                    state_d = START;
`ifdef TX_UART_PARITY_EN
                    par_d   = (^mem[rd_ptr]) ^ bus.parity_odd;
`endif
                end
            end
            START: begin
                if (timer_q == '0) begin
                    pin_d   = shift_q[0];
                    timer_d = bus.baud_div;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    timer_d = bus.baud_div;
                    if (idx_q == 3'd7) begin
`ifdef TX_UART_PARITY_EN
                        pin_d   = par_q;
                        state_d = PARITY;
`else
                        pin_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        pin_d   = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef TX_UART_PARITY_EN
            PARITY: begin
                if (timer_q == '0) begin
                    pin_d   = 1'b1;
                    timer_d = bus.baud_div;
                    state_d = STOP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            STOP: begin
                pin_d = 1'b1;
                if (timer_q == '0)
                    state_d = IDLE;
                else
                    timer_d = timer_q - 1'b1;
            end
            default: begin
                pin_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_pin    = pin_q;
    assign bus.tx_busy   = (state_q != IDLE);
    assign bus.tx_full   = full_q;
    assign bus.tx_empty  = empty_q;
    assign bus.state_dbg = state_q;
endmodule
